// File: rtl/acc_frame_pkg.sv
// Shared types and defaults for the accumulator frame serializer.
// The checksum state only exists when CHECKSUM_EN is defined.
package acc_frame_pkg;

  localparam logic [7:0] HDR_BYTE_DEF   = 8'h80;
  localparam logic [7:0] START_CODE_DEF = 8'h02;
  localparam logic [7:0] END_CODE_DEF   = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_POP,
    ST_CHECK,
`ifdef CHECKSUM_EN
    ST_CSUM,
`endif
    ST_TRL0,
    ST_TRL1
  } state_t;

  function automatic int w8(input int word_bytes);
    return word_bytes * 8;
  endfunction

endpackage

// File: rtl/acc_frame_byte_sel.sv
// Combinational byte picker: byte byte_idx (0 = most significant) of channel ch's word.
// Out-of-range selects return zero.
module acc_frame_byte_sel
  import acc_frame_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WORD_BYTES = 2,
  parameter int CW         = 2,
  parameter int BW         = 1
) (
  input  logic [NUM_CH*WORD_BYTES*8-1:0] ch_data,
  input  logic [CW-1:0]                  ch,
  input  logic [BW-1:0]                  byte_idx,
  output logic [7:0]                     byte_out
);

  localparam int W8 = w8(WORD_BYTES);

  always_comb begin
    byte_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (ch == CW'(c) && byte_idx == BW'(b)) begin
          byte_out = ch_data[c*W8 + (WORD_BYTES-1-b)*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/acc_frame_serializer.sv
// Frames enabled accumulator channels into a byte stream (header, records, optional CHECKSUM_EN sum, trailer).
// Registered valid/ready output, one byte per transfer; ByteReady low stalls the FSM with no channel pops.
module acc_frame_serializer
  import acc_frame_pkg::*;
#(
  parameter int         NUM_CH     = 4,
  parameter int         WORD_BYTES = 2,
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF,
  parameter logic [7:0] START_CODE = START_CODE_DEF,
  parameter logic [7:0] END_CODE   = END_CODE_DEF
) (
  input  logic                          ReadClock,
  input  logic                          Reset,
  input  logic [NUM_CH*WORD_BYTES*8-1:0] ChData,
  input  logic [NUM_CH-1:0]             ChReady,
  output logic [NUM_CH-1:0]             ChRead,
  input  logic [NUM_CH-1:0]             ChMask,
  input  logic [7:0]                    MaxRecords,
  output logic [7:0]                    ByteData,
  output logic                          ByteValid,
  input  logic                          ByteReady,
  output logic                          Busy,
  output logic                          FrameDone,
  output logic [7:0]                    RecordCount
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  state_t              state;
  logic [NUM_CH-1:0]   mask_q;
  logic [CW-1:0]       cur_ch;
  logic [BW-1:0]       byte_idx;
`ifdef CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic                xfer;
  logic                last_byte;
  logic                all_ready;
  logic                cap_ok;
  logic [CW-1:0]       first_ch;
  logic [CW-1:0]       next_ch;
  logic                has_next;
  logic [NUM_CH-1:0]   cur_onehot;
  logic [CW-1:0]       sel_ch;
  logic [BW-1:0]       sel_byte;
  logic [7:0]          sel_out;

  assign xfer      = ByteValid & ByteReady;
  assign last_byte = (byte_idx == BW'(WORD_BYTES-1));
  assign all_ready = ((ChReady & mask_q) == mask_q);
  assign cap_ok    = (MaxRecords == 8'd0) || (RecordCount < MaxRecords);
  assign Busy      = (state != ST_IDLE);

  // Descending scan so the lowest enabled index wins for both searches.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (mask_q[c]) begin
        first_ch = CW'(c);
        if (c > int'(cur_ch)) begin
          next_ch  = CW'(c);
          has_next = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cur_onehot = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cur_onehot[c] = (cur_ch == CW'(c));
    end
  end

  // The mux always looks one byte ahead of what is on ByteData.
  always_comb begin
    sel_ch   = cur_ch;
    sel_byte = byte_idx + BW'(1);
    case (state)
      ST_POP: begin
        sel_ch   = next_ch;
        sel_byte = '0;
      end
      ST_CHECK: begin
        sel_ch   = first_ch;
        sel_byte = '0;
      end
      default: ;
    endcase
  end

  acc_frame_byte_sel #(
    .NUM_CH     (NUM_CH),
    .WORD_BYTES (WORD_BYTES),
    .CW         (CW),
    .BW         (BW)
  ) u_byte_sel (
    .ch_data  (ChData),
    .ch       (sel_ch),
    .byte_idx (sel_byte),
    .byte_out (sel_out)
  );

  always_ff @(posedge ReadClock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      mask_q      <= '0;
      cur_ch      <= '0;
      byte_idx    <= '0;
      ChRead      <= '0;
      ByteData    <= '0;
      ByteValid   <= 1'b0;
      FrameDone   <= 1'b0;
      RecordCount <= '0;
`ifdef CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      ChRead    <= '0;
      FrameDone <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef CHECKSUM_EN
          csum <= '0;
`endif
          if (|(ChReady & ChMask)) begin
            mask_q      <= ChMask;
            RecordCount <= '0;
            ByteData    <= HDR_BYTE;
            ByteValid   <= 1'b1;
            state       <= ST_HDR0;
          end
        end
        ST_HDR0: if (xfer) begin
          ByteData <= START_CODE;
          state    <= ST_HDR1;
        end
        // First record goes through CHECK so a partial record is never started.
        ST_HDR1: if (xfer) begin
          ByteValid <= 1'b0;
          state     <= ST_CHECK;
        end
        ST_PAYLOAD: if (xfer) begin
`ifdef CHECKSUM_EN
          csum <= csum + ByteData;
`endif
          if (last_byte) begin
            ByteValid <= 1'b0;
            ChRead    <= cur_onehot;
            state     <= ST_POP;
          end else begin
            byte_idx <= byte_idx + BW'(1);
            ByteData <= sel_out;
          end
        end
        ST_POP: begin
          if (has_next) begin
            cur_ch    <= next_ch;
            byte_idx  <= '0;
            ByteData  <= sel_out;
            ByteValid <= 1'b1;
            state     <= ST_PAYLOAD;
          end else begin
            if (RecordCount != 8'hFF) begin
              RecordCount <= RecordCount + 8'd1;
            end
            state <= ST_CHECK;
          end
        end
        // Entered one cycle after the final pop, so ChReady already reflects it.
        ST_CHECK: begin
          ByteValid <= 1'b1;
          if (all_ready && cap_ok) begin
            cur_ch   <= first_ch;
            byte_idx <= '0;
            ByteData <= sel_out;
            state    <= ST_PAYLOAD;
          end else begin
`ifdef CHECKSUM_EN
            ByteData <= csum;
            state    <= ST_CSUM;
`else
            ByteData <= HDR_BYTE;
            state    <= ST_TRL0;
`endif
          end
        end
`ifdef CHECKSUM_EN
        ST_CSUM: if (xfer) begin
          ByteData <= HDR_BYTE;
          state    <= ST_TRL0;
        end
`endif
        ST_TRL0: if (xfer) begin
          ByteData <= END_CODE;
          state    <= ST_TRL1;
        end
        ST_TRL1: if (xfer) begin
          ByteValid <= 1'b0;
          FrameDone <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          ByteValid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_frame_serializer.sv
// Directed bench for acc_frame_serializer with a FWFT source model per channel and a byte-stream collector.
module tb_acc_frame_serializer;

  localparam int NUM_CH = 4;
  localparam int WB     = 2;

  logic              ReadClock = 1'b0;
  logic              Reset     = 1'b1;
  logic [63:0]       ChData;
  logic [3:0]        ChReady;
  logic [3:0]        ChRead;
  logic [3:0]        ChMask     = 4'h0;
  logic [7:0]        MaxRecords = 8'd0;
  logic [7:0]        ByteData;
  logic              ByteValid;
  logic              ByteReady  = 1'b1;
  logic              Busy;
  logic              FrameDone;
  logic [7:0]        RecordCount;

  int checks   = 0;
  int failures = 0;

  always #5 ReadClock = ~ReadClock;

  acc_frame_serializer #(.NUM_CH(NUM_CH), .WORD_BYTES(WB)) dut (
    .ReadClock   (ReadClock),
    .Reset       (Reset),
    .ChData      (ChData),
    .ChReady     (ChReady),
    .ChRead      (ChRead),
    .ChMask      (ChMask),
    .MaxRecords  (MaxRecords),
    .ByteData    (ByteData),
    .ByteValid   (ByteValid),
    .ByteReady   (ByteReady),
    .Busy        (Busy),
    .FrameDone   (FrameDone),
    .RecordCount (RecordCount)
  );

  // Channel sources: 16-deep FWFT queues, popped by ChRead.
  logic [15:0] mem [NUM_CH][16];
  logic [3:0]  wr_ptr [NUM_CH] = '{default: 4'd0};
  logic [3:0]  rd_ptr [NUM_CH] = '{default: 4'd0};
  logic        flush = 1'b0;

  always_comb begin
    ChReady = '0;
    ChData  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ChReady[c]        = (wr_ptr[c] != rd_ptr[c]);
      ChData[c*16 +: 16] = mem[c][rd_ptr[c]];
    end
  end

  always @(posedge ReadClock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (flush) rd_ptr[c] <= wr_ptr[c];
      else if (ChRead[c]) rd_ptr[c] <= rd_ptr[c] + 4'd1;
    end
  end

  int rdy_mode = 1;
  always @(posedge ReadClock) begin
    #1;
    ByteReady = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor, sampled on the falling edge.
  logic [7:0] cap [0:1023];
  int   ncap = 0;
  int   pulses [NUM_CH] = '{default: 0};
  int   dbl_err = 0, hold_err = 0, fd_cnt = 0;
  logic [3:0] prev_rd = '0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = '0;

  always @(negedge ReadClock) begin
    if (ByteValid && ByteReady) begin
      cap[ncap[9:0]] = ByteData;
      ncap++;
    end
    if (prev_stall && (!ByteValid || ByteData != prev_dat)) hold_err++;
    prev_stall = ByteValid && !ByteReady;
    prev_dat   = ByteData;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ChRead[c]) pulses[c]++;
      if (ChRead[c] && prev_rd[c]) dbl_err++;
    end
    prev_rd = ChRead;
    if (FrameDone) fd_cnt++;
  end

  // Expected-stream model.
  logic [7:0] exp_q[$];
  logic [7:0] exp_sum;

  task automatic exp_begin();
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h02);
    exp_sum = 8'h00;
  endtask

  task automatic exp_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_sum = exp_sum + w[15:8] + w[7:0];
  endtask

  task automatic exp_end();
`ifdef CHECKSUM_EN
    exp_q.push_back(exp_sum);
`endif
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h01);
  endtask

  task automatic push(input int c, input logic [15:0] w);
    mem[c][wr_ptr[c]] = w;
    wr_ptr[c] = wr_ptr[c] + 4'd1;
  endtask

  task automatic do_flush();
    @(negedge ReadClock);
    flush = 1'b1;
    @(negedge ReadClock);
    flush = 1'b0;
    @(negedge ReadClock);
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ReadClock);
      if (FrameDone) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] wval(input int r, input int c);
    return 16'((r + 1) * 16'h1010 + (c + 1) * 16'h0101);
  endfunction

  localparam logic [15:0] T1_WORDS [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge ReadClock);
    checks++; if (ByteValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ByteValid); end
    checks++; if (ByteData !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", ByteData); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (FrameDone !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", FrameDone); end
    checks++; if (RecordCount !== 8'd0) begin failures++; $display("FAIL reset_reccount got=%0d exp=0", RecordCount); end
    checks++; if (ChRead !== 4'h0) begin failures++; $display("FAIL reset_chread got=%b exp=0000", ChRead); end
    Reset = 1'b0;
    @(negedge ReadClock);
  endtask

  // Shared body for the unthrottled and throttled single-record frames.
  task automatic run_t1(input string name, input int budget);
    int base, fd0, dbl0, hold0;
    int p0 [NUM_CH];
    bit ok;
    p0 = pulses; base = ncap; fd0 = fd_cnt; dbl0 = dbl_err; hold0 = hold_err;
    exp_q.delete();
    exp_begin();
    for (int c = 0; c < 4; c++) begin
      push(c, T1_WORDS[c]);
      exp_word(T1_WORDS[c]);
    end
    exp_end();
    ChMask = 4'hF;
    wait_frame(budget, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_timeout got=no_done exp=done", name); end
    checks++; if (RecordCount !== 8'd1) begin failures++; $display("FAIL %s_reccount got=%0d exp=1", name, RecordCount); end
    repeat (3) @(negedge ReadClock);
    checks++; if (fd_cnt - fd0 != 1) begin failures++; $display("FAIL %s_donecount got=%0d exp=1", name, fd_cnt - fd0); end
    checks++; if (ncap - base != exp_q.size()) begin failures++; $display("FAIL %s_len got=%0d exp=%0d", name, ncap - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cap[(base + i) % 1024] !== exp_q[i]) begin
        failures++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, cap[(base + i) % 1024], exp_q[i]);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++; if (pulses[c] - p0[c] != 1) begin failures++; $display("FAIL %s_pops_ch%0d got=%0d exp=1", name, c, pulses[c] - p0[c]); end
    end
    checks++; if (dbl_err != dbl0) begin failures++; $display("FAIL %s_pulse_width got=%0d exp=%0d", name, dbl_err, dbl0); end
    checks++; if (hold_err != hold0) begin failures++; $display("FAIL %s_hold got=%0d exp=%0d", name, hold_err, hold0); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL %s_busy_after got=%b exp=0", name, Busy); end
    ChMask = 4'h0;
  endtask

  task automatic test_full_frame();
    run_t1("full", 200);
  endtask

  task automatic test_backpressure();
    rdy_mode = 2;
    run_t1("bp", 2000);
    rdy_mode = 1;
    repeat (2) @(negedge ReadClock);
  endtask

  task automatic test_mask();
    int base;
    int p0 [NUM_CH];
    bit ok;
    p0 = pulses; base = ncap;
    exp_q.delete();
    push(0, 16'hA1B2); push(1, 16'hC3D4); push(2, 16'hE5F6); push(3, 16'h0718);
    exp_begin(); exp_word(16'hA1B2); exp_word(16'hE5F6); exp_end();
    ChMask = 4'b0101;
    wait_frame(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mask_timeout got=no_done exp=done"); end
    checks++; if (RecordCount !== 8'd1) begin failures++; $display("FAIL mask_reccount got=%0d exp=1", RecordCount); end
    repeat (5) @(negedge ReadClock);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mask_idle got=%b exp=0", Busy); end
    checks++; if (ncap - base != exp_q.size()) begin failures++; $display("FAIL mask_len got=%0d exp=%0d", ncap - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cap[(base + i) % 1024] !== exp_q[i]) begin
        failures++; $display("FAIL mask_byte%0d got=%h exp=%h", i, cap[(base + i) % 1024], exp_q[i]);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (pulses[c] - p0[c] != ((c % 2 == 0) ? 1 : 0)) begin
        failures++; $display("FAIL mask_pops_ch%0d got=%0d exp=%0d", c, pulses[c] - p0[c], (c % 2 == 0) ? 1 : 0);
      end
    end
    ChMask = 4'h0;
    do_flush();
  endtask

  task automatic test_max_records();
    int base;
    bit ok;
    base = ncap;
    exp_q.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NUM_CH; c++) push(c, wval(r, c));
    exp_begin();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NUM_CH; c++) exp_word(wval(r, c));
    exp_end();
    exp_begin();
    for (int c = 0; c < NUM_CH; c++) exp_word(wval(2, c));
    exp_end();
    MaxRecords = 8'd2;
    ChMask = 4'hF;
    wait_frame(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cap_timeout1 got=no_done exp=done"); end
    checks++; if (RecordCount !== 8'd2) begin failures++; $display("FAIL cap_reccount1 got=%0d exp=2", RecordCount); end
    wait_frame(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cap_timeout2 got=no_done exp=done"); end
    checks++; if (RecordCount !== 8'd1) begin failures++; $display("FAIL cap_reccount2 got=%0d exp=1", RecordCount); end
    repeat (3) @(negedge ReadClock);
    checks++; if (ncap - base != exp_q.size()) begin failures++; $display("FAIL cap_len got=%0d exp=%0d", ncap - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cap[(base + i) % 1024] !== exp_q[i]) begin
        failures++; $display("FAIL cap_byte%0d got=%h exp=%h", i, cap[(base + i) % 1024], exp_q[i]);
      end
    end
    MaxRecords = 8'd0;
    ChMask = 4'h0;
  endtask

  task automatic test_reset_abort();
    int base, fd0;
    bit seen;
    seen = 1'b0;
    fd0 = fd_cnt;
    for (int c = 0; c < 4; c++) push(c, T1_WORDS[c]);
    ChMask = 4'hF;
    // Fifth payload byte of the frame is 9A (channel 2, MSB).
    for (int i = 0; i < 200; i++) begin
      @(negedge ReadClock);
      if (ByteValid && ByteData == 8'h9A) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL abort_reach got=no_byte5 exp=byte5"); end
    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", Busy); end
    Reset = 1'b1;
    ChMask = 4'h0;
    @(negedge ReadClock);
    checks++; if (ByteValid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", ByteValid); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", Busy); end
    checks++; if (ChRead !== 4'h0) begin failures++; $display("FAIL abort_chread got=%b exp=0000", ChRead); end
    base = ncap;
    Reset = 1'b0;
    repeat (20) @(negedge ReadClock);
    checks++; if (ncap != base) begin failures++; $display("FAIL abort_no_trailer got=%0d exp=0 bytes", ncap - base); end
    checks++; if (fd_cnt != fd0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", fd_cnt - fd0); end
    do_flush();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_mask();
    test_max_records();
    test_backpressure();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
